pulse_cmd_scheduler: RTL and testbench

PULSE_CMD_SCHEDULER -- requirements
Module: pulse_cmd_scheduler

---
 rtl/pulse_cmd_scheduler.sv | 119 +++++++++++
 tb/tb_pulse_cmd_scheduler.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/pulse_cmd_scheduler.sv
// Arbitrates pulse-generator FIFO writes between the start-up sequence, periodic
// sync commands and two requesters; counts sync ticks lost to back-pressure.
module pulse_cmd_scheduler #(
  parameter int CNT_W = 16,
  parameter int INT_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [23:0]      cfg_period,
  input  logic [INT_W-1:0] cfg_sync_interval,
  input  logic [15:0]      cfg_sync_coarse,
  input  logic [7:0]       cfg_sync_fine,
  input  logic [31:0]      req0_data,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req1_data,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic             fifo_full,
  output logic [31:0]      fifo_din,
  output logic             fifo_wr,
  output logic             running,
  output logic [CNT_W-1:0] missed_count
);

  typedef enum logic [1:0] {IDLE, SEND_PERIOD, SEND_RESET, RUN} state_e;

  state_e           state_q, state_d;
  logic [INT_W-1:0] timer_q, timer_d;
  logic             pend_q, pend_d;
  logic [CNT_W-1:0] missed_q, missed_d;
  logic             rr_q, rr_d;  // 0: req0 favoured on a tie, 1: req1

  logic in_send, in_run, tick, seq_wr, sync_wr, gnt0, gnt1, elig0, elig1;

  always_comb begin
    in_send = (state_q == SEND_PERIOD) || (state_q == SEND_RESET);
    in_run  = (state_q == RUN);
    tick    = in_run && (cfg_sync_interval != '0) &&
              (timer_q >= cfg_sync_interval - INT_W'(1));
    seq_wr  = 1'b0;
    sync_wr = 1'b0;
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    elig0   = req0_valid && ((state_q == IDLE) || in_run);
    elig1   = req1_valid && in_run;
    if (!rst && !fifo_full) begin
      // stop abandons a sequence word that has not gone out yet
      if (in_send)              seq_wr  = !stop;
      else if (in_run && pend_q) sync_wr = 1'b1;
      else begin
        gnt0 = elig0 && (!elig1 || !rr_q);
        gnt1 = elig1 && (!elig0 ||  rr_q);
      end
    end
    fifo_wr    = seq_wr | sync_wr | gnt0 | gnt1;
    req0_ready = gnt0;
    req1_ready = gnt1;
    fifo_din   = 32'h0;
    if (seq_wr)       fifo_din = (state_q == SEND_PERIOD) ? {8'h02, cfg_period} : 32'h0;
    else if (sync_wr) fifo_din = {8'h01, cfg_sync_coarse, cfg_sync_fine};
    else if (gnt0)    fifo_din = req0_data;
    else if (gnt1)    fifo_din = req1_data;
  end

  always_comb begin
    state_d = state_q;
    if (stop) state_d = IDLE;
    else begin
      case (state_q)
        IDLE:        if (start)  state_d = SEND_PERIOD;
        SEND_PERIOD: if (seq_wr) state_d = SEND_RESET;
        SEND_RESET:  if (seq_wr) state_d = RUN;
        RUN:         if (start)  state_d = SEND_PERIOD;
        default:                 state_d = IDLE;
      endcase
    end

    // Timer restarts from 0 on RUN entry and idles at 0 elsewhere
    timer_d = '0;
    if (in_run && (state_d == RUN) && (cfg_sync_interval != '0))
      timer_d = tick ? '0 : timer_q + INT_W'(1);

    pend_d = pend_q;
    if (state_d != RUN) pend_d = 1'b0;
    else if (tick)      pend_d = 1'b1;
    else if (sync_wr)   pend_d = 1'b0;

    missed_d = missed_q;
    if (start) missed_d = '0;
    else if (tick && pend_q && !sync_wr && !(&missed_q)) missed_d = missed_q + CNT_W'(1);

    rr_d = rr_q;
    if (gnt0)      rr_d = 1'b1;
    else if (gnt1) rr_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      pend_q   <= 1'b0;
      missed_q <= '0;
      rr_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      pend_q   <= pend_d;
      missed_q <= missed_d;
      rr_q     <= rr_d;
    end
  end

  assign running      = in_run;
  assign missed_count = missed_q;

endmodule

// File: tb/tb_pulse_cmd_scheduler.sv
// Randomized bench for pulse_cmd_scheduler against a cycle-level behavioural model.
module tb_pulse_cmd_scheduler;
  localparam int CNT_W = 3;
  localparam int INT_W = 24;
  localparam int MAXM  = (1 << CNT_W) - 1;
  localparam int M_IDLE = 0, M_SP = 1, M_SR = 2, M_RUN = 3;

  logic clk = 0, rst = 1, start = 0, stop = 0;
  logic [23:0] cfg_period = 0;
  logic [INT_W-1:0] cfg_sync_interval = 0;
  logic [15:0] cfg_sync_coarse = 0;
  logic [7:0] cfg_sync_fine = 0;
  logic [31:0] req0_data = 0, req1_data = 0, fifo_din;
  logic req0_valid = 0, req1_valid = 0, req0_ready, req1_ready;
  logic fifo_full = 0, fifo_wr, running;
  logic [CNT_W-1:0] missed_count;

  pulse_cmd_scheduler #(.CNT_W(CNT_W), .INT_W(INT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .cfg_period(cfg_period),
    .cfg_sync_interval(cfg_sync_interval), .cfg_sync_coarse(cfg_sync_coarse),
    .cfg_sync_fine(cfg_sync_fine), .req0_data(req0_data), .req0_valid(req0_valid),
    .req0_ready(req0_ready), .req1_data(req1_data), .req1_valid(req1_valid),
    .req1_ready(req1_ready), .fifo_full(fifo_full), .fifo_din(fifo_din),
    .fifo_wr(fifo_wr), .running(running), .missed_count(missed_count)
  );

  always #5 clk = ~clk;

  int nvec = 0, nerr = 0;
  int m_st, m_runcyc, m_missed;
  bit m_pend, m_rr1;
  bit e_wr, e_g0, e_g1, e_sync, e_tick;
  logic [31:0] e_din;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = M_IDLE; m_runcyc = 0; m_missed = 0; m_pend = 0; m_rr1 = 0;
  endtask

  // Expected outputs from the current model state and applied inputs
  task automatic model_eval();
    int n;
    bit a0, a1;
    n = int'(cfg_sync_interval);
    e_tick = (m_st == M_RUN) && (n != 0) && ((m_runcyc % n) == n - 1);
    e_wr = 0; e_din = 0; e_g0 = 0; e_g1 = 0; e_sync = 0;
    if (!rst && !fifo_full) begin
      if (m_st == M_SP || m_st == M_SR) begin
        if (!stop) begin
          e_wr = 1;
          e_din = (m_st == M_SP) ? {8'h02, cfg_period} : 32'h0;
        end
      end else if (m_st == M_RUN && m_pend) begin
        e_wr = 1; e_sync = 1; e_din = {8'h01, cfg_sync_coarse, cfg_sync_fine};
      end else begin
        a0 = req0_valid;
        a1 = req1_valid && (m_st == M_RUN);
        if (a0 && a1) begin e_g0 = !m_rr1; e_g1 = m_rr1; end
        else begin e_g0 = a0; e_g1 = a1; end
        e_wr = e_g0 | e_g1;
        if (e_g0) e_din = req0_data;
        if (e_g1) e_din = req1_data;
      end
    end
  endtask

  task automatic model_update();
    int nst;
    bit seqw;
    seqw = e_wr && (m_st == M_SP || m_st == M_SR);
    nst = m_st;
    if (stop) nst = M_IDLE;
    else if (m_st == M_IDLE && start) nst = M_SP;
    else if (m_st == M_SP && seqw) nst = M_SR;
    else if (m_st == M_SR && seqw) nst = M_RUN;
    else if (m_st == M_RUN && start) nst = M_SP;
    if (start) m_missed = 0;
    else if (e_tick && m_pend && !e_sync && m_missed < MAXM) m_missed++;
    if (nst != M_RUN) m_pend = 0;
    else if (e_tick) m_pend = 1;
    else if (e_sync) m_pend = 0;
    m_runcyc = (nst == M_RUN && m_st == M_RUN) ? m_runcyc + 1 : 0;
    if (e_g0) m_rr1 = 1;
    else if (e_g1) m_rr1 = 0;
    m_st = nst;
  endtask

  // Called just after a falling edge with inputs applied; leaves at the next one
  task automatic step();
    #1;
    if (rst) model_reset();
    model_eval();
    chk("fifo_wr", 32'(fifo_wr), 32'(e_wr));
    chk("fifo_din", fifo_din, e_din);
    chk("req0_ready", 32'(req0_ready), 32'(e_g0));
    chk("req1_ready", 32'(req1_ready), 32'(e_g1));
    chk("running", 32'(running), 32'(m_st == M_RUN));
    chk("missed_count", 32'(missed_count), 32'(m_missed));
    @(posedge clk);
    if (rst) model_reset(); else model_update();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse_start();
    start = 1; step(); start = 0;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    idle(3);                                     // reset state
    rst = 0;
    idle(2);
    req0_valid = 1; req0_data = 32'hA5A5_0001;   // IDLE: only req0 eligible
    req1_valid = 1; req1_data = 32'h5A5A_0002;
    idle(3);
    req0_valid = 0; req1_valid = 0;

    cfg_period = 24'h000010;                     // start-up sequence
    pulse_start();
    idle(3);

    cfg_sync_interval = 5; cfg_sync_coarse = 16'h0102; cfg_sync_fine = 8'h03;
    pulse_start();                               // restart so N=5 applies from RUN entry
    idle(24);

    req0_valid = 1; req1_valid = 1;              // alternation with sync pre-emption
    idle(16);
    req0_valid = 0; req1_valid = 0;

    fifo_full = 1; idle(12);                     // back-pressure loses ticks
    fifo_full = 0; idle(8);

    pulse_start();                               // stop in SEND_RESET while full
    step();
    fifo_full = 1; idle(2);
    stop = 1; step(); stop = 0;
    fifo_full = 0; idle(3);
    start = 1; stop = 1; step(); start = 0; stop = 0;
    idle(3);

    cfg_sync_interval = 1;                       // saturate the small counter
    pulse_start();
    idle(3);
    fifo_full = 1; idle(14);
    fifo_full = 0; idle(3);

    cfg_sync_interval = 4;                       // reset mid-RUN with sync pending
    pulse_start();
    idle(6);
    fifo_full = 1; idle(3);
    rst = 1; step(); step();
    rst = 0; fifo_full = 0; idle(6);

    for (int c = 0; c < 3000; c++) begin
      start = ($urandom_range(0, 39) == 0);
      stop  = ($urandom_range(0, 59) == 0);
      rst   = ($urandom_range(0, 399) == 0);
      if (start) cfg_sync_interval = INT_W'($urandom_range(0, 7));
      if ($urandom_range(0, 15) == 0) cfg_period = 24'($urandom);
      if ($urandom_range(0, 15) == 0) begin
        cfg_sync_coarse = 16'($urandom); cfg_sync_fine = 8'($urandom);
      end
      req0_valid = ($urandom_range(0, 2) != 0); req0_data = $urandom;
      req1_valid = ($urandom_range(0, 2) != 0); req1_data = $urandom;
      fifo_full  = ($urandom_range(0, 3) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
